// File: rtl/avr_cpu_seq_pkg.sv
// Shared types and opcode classification for the AVR decode sequencer.
// Cycle counts are raw; the info block saturates them to the configured maximum.
package avr_cpu_seq_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StExt,
        StIssue,
        StSkipX
    } seq_state_e;

    localparam logic [15:0] JmpCallMask  = 16'hFE0C;
    localparam logic [15:0] JmpCallMatch = 16'h940C;
    localparam logic [15:0] LdsStsMask   = 16'hFC0F;
    localparam logic [15:0] LdsStsMatch  = 16'h9000;

    function automatic logic is_two_word_op(input logic [15:0] op);
        return ((op & JmpCallMask) == JmpCallMatch) || ((op & LdsStsMask) == LdsStsMatch);
    endfunction

    function automatic int unsigned insn_cycles(input logic [15:0] op);
        if ((op & JmpCallMask) == JmpCallMatch) begin
            // bit 1 distinguishes CALL (940E) from JMP (940C)
            return op[1] ? 4 : 3;
        end else if (op == 16'h9508 || op == 16'h9518) begin
            return 4;
        end else if (op == 16'h95C8 || (op & 16'hFE0E) == 16'h9004) begin
            return 3;
        end else if ((op & 16'hFD00) == 16'h9800) begin
            return 2;
        end else if ((op & LdsStsMask) == LdsStsMatch) begin
            return 2;
        end else if (op[15:12] == 4'hC) begin
            return 2;
        end else if (op[15:12] == 4'hD) begin
            return 3;
        end
        return 1;
    endfunction

endpackage

// File: rtl/avr_cpu_insn_info.sv
// Combinational opcode classifier: two-word flag and index of the final cycle slot.
module avr_cpu_insn_info
    import avr_cpu_seq_pkg::*;
#(
    parameter int unsigned MAX_CYCLES  = 4,
    parameter int unsigned TWO_WORD_EN = 1,
    parameter int unsigned CW          = 2
) (
    input  logic [15:0]   opcode_i,
    output logic          is_two_word_o,
    // Saturated cycle count minus one, so MAX_CYCLES fits in CW bits.
    output logic [CW-1:0] cycles_o
);

    int unsigned raw_cycles;
    int unsigned sat_cycles;

    always_comb begin
        raw_cycles = insn_cycles(opcode_i);
        sat_cycles = (raw_cycles > MAX_CYCLES) ? MAX_CYCLES : raw_cycles;
        if (sat_cycles == 0) begin
            sat_cycles = 1;
        end
        cycles_o      = CW'(sat_cycles - 1);
        is_two_word_o = (TWO_WORD_EN != 0) && is_two_word_op(opcode_i);
    end

endmodule

// File: rtl/avr_cpu_decode_seq.sv
// Multi-cycle instruction sequencer: assembles two-word ops, issues per-cycle slots,
// and applies skip-next and branch flush before execute sees anything.
module avr_cpu_decode_seq
    import avr_cpu_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned MAX_CYCLES  = 4,
    parameter int unsigned TWO_WORD_EN = 1,
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                op_valid_i,
    input  logic [15:0]         op_data_i,
    output logic                op_ready_o,
    input  logic                flush_i,
    input  logic                skip_req_i,
    input  logic                exec_ready_i,
    output logic                dec_valid_o,
    output logic [15:0]         dec_opcode_o,
    output logic [PC_WIDTH-1:0] dec_ext_o,
    output logic                dec_two_word_o,
    output logic [CW-1:0]       dec_cycle_o,
    output logic                dec_last_o
);

    seq_state_e          state_q, state_d;
    logic [15:0]         opcode_q, opcode_d;
    logic [PC_WIDTH-1:0] ext_q, ext_d;
    logic                two_word_q, two_word_d;
    logic [CW-1:0]       cycle_q, cycle_d;
    logic [CW-1:0]       last_idx_q, last_idx_d;
    logic                skip_pending_q, skip_pending_d;
    logic                init_q;

    logic                word_two;
    logic [CW-1:0]       word_last_idx;
    logic                is_last;
    logic                retire;
    logic                accept;
    logic                skip_eff;

    avr_cpu_insn_info #(
        .MAX_CYCLES  (MAX_CYCLES),
        .TWO_WORD_EN (TWO_WORD_EN),
        .CW          (CW)
    ) u_info (
        .opcode_i      (op_data_i),
        .is_two_word_o (word_two),
        .cycles_o      (word_last_idx)
    );

    assign is_last = (cycle_q == last_idx_q);
    assign retire  = (state_q == StIssue) && exec_ready_i && is_last;
    // A word arriving on the retire cycle sees the skip_req sampled on that same retire.
    assign skip_eff = retire ? skip_req_i : skip_pending_q;

    always_comb begin
        op_ready_o = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                StEmpty, StExt, StSkipX: op_ready_o = init_q;
                StIssue:                 op_ready_o = is_last && exec_ready_i;
                default:                 op_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = op_valid_i && op_ready_o;

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        ext_d          = ext_q;
        two_word_d     = two_word_q;
        cycle_d        = cycle_q;
        last_idx_d     = last_idx_q;
        skip_pending_d = skip_pending_q;

        if (flush_i) begin
            state_d        = StEmpty;
            skip_pending_d = 1'b0;
            opcode_d       = '0;
            ext_d          = '0;
            two_word_d     = 1'b0;
            cycle_d        = '0;
            last_idx_d     = '0;
        end else begin
            unique case (state_q)
                StExt: begin
                    if (accept) begin
                        ext_d   = PC_WIDTH'(op_data_i);
                        cycle_d = '0;
                        state_d = StIssue;
                    end
                end
                StSkipX: begin
                    if (accept) begin
                        state_d = StEmpty;
                    end
                end
                StIssue: begin
                    if (exec_ready_i) begin
                        if (!is_last) begin
                            cycle_d = CW'(cycle_q + 1'b1);
                        end else begin
                            state_d        = StEmpty;
                            skip_pending_d = skip_req_i;
                        end
                    end
                end
                default: ;
            endcase

            // First word of a new instruction, from EMPTY or on the retire cycle.
            if (accept && (state_q == StEmpty || retire)) begin
                if (skip_eff) begin
                    skip_pending_d = 1'b0;
                    state_d        = word_two ? StSkipX : StEmpty;
                end else begin
                    opcode_d   = op_data_i;
                    ext_d      = '0;
                    two_word_d = word_two;
                    last_idx_d = word_last_idx;
                    cycle_d    = '0;
                    state_d    = word_two ? StExt : StIssue;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StEmpty;
            opcode_q       <= '0;
            ext_q          <= '0;
            two_word_q     <= 1'b0;
            cycle_q        <= '0;
            last_idx_q     <= '0;
            skip_pending_q <= 1'b0;
            init_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            ext_q          <= ext_d;
            two_word_q     <= two_word_d;
            cycle_q        <= cycle_d;
            last_idx_q     <= last_idx_d;
            skip_pending_q <= skip_pending_d;
            init_q         <= 1'b1;
        end
    end

    assign dec_valid_o    = (state_q == StIssue);
    assign dec_opcode_o   = opcode_q;
    assign dec_ext_o      = ext_q;
    assign dec_two_word_o = two_word_q;
    assign dec_cycle_o    = cycle_q;
    assign dec_last_o     = dec_valid_o && is_last;

endmodule

// File: tb/tb_avr_cpu_decode_seq.sv
// Directed bench for avr_cpu_decode_seq with hand-computed expectations.
module tb_avr_cpu_decode_seq;

    localparam int unsigned CW = 2;

    logic        clk;
    logic        rst_ni;
    logic        op_valid;
    logic [15:0] op_data;
    logic        op_ready;
    logic        flush;
    logic        skip_req;
    logic        exec_ready;
    logic        dec_valid;
    logic [15:0] dec_opcode;
    logic [15:0] dec_ext;
    logic        dec_two_word;
    logic [CW-1:0] dec_cycle;
    logic        dec_last;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    avr_cpu_decode_seq #(
        .PC_WIDTH    (16),
        .MAX_CYCLES  (4),
        .TWO_WORD_EN (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .op_valid_i     (op_valid),
        .op_data_i      (op_data),
        .op_ready_o     (op_ready),
        .flush_i        (flush),
        .skip_req_i     (skip_req),
        .exec_ready_i   (exec_ready),
        .dec_valid_o    (dec_valid),
        .dec_opcode_o   (dec_opcode),
        .dec_ext_o      (dec_ext),
        .dec_two_word_o (dec_two_word),
        .dec_cycle_o    (dec_cycle),
        .dec_last_o     (dec_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input logic [15:0] opc, input int cyc, input logic last,
                        input logic rdy);
        #1;
        check({tag, ".valid"}, 32'(dec_valid), 32'd1);
        check({tag, ".opcode"}, 32'(dec_opcode), 32'(opc));
        check({tag, ".cycle"}, 32'(dec_cycle), 32'(cyc));
        check({tag, ".last"}, 32'(dec_last), 32'(last));
        check({tag, ".ready"}, 32'(op_ready), 32'(rdy));
    endtask

    initial begin
        rst_ni     = 1'b0;
        op_valid   = 1'b0;
        op_data    = 16'h0000;
        flush      = 1'b0;
        skip_req   = 1'b0;
        exec_ready = 1'b1;

        #1;
        check("rst.valid", 32'(dec_valid), 32'd0);
        check("rst.ready", 32'(op_ready), 32'd0);
        check("rst.opcode", 32'(dec_opcode), 32'd0);
        check("rst.last", 32'(dec_last), 32'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        check("rel.ready0", 32'(op_ready), 32'd0);
        tick();
        #1;
        check("rel.ready1", 32'(op_ready), 32'd1);

        // ADD then MOV back to back
        op_valid = 1'b1;
        op_data  = 16'h0C01;
        tick();
        op_data = 16'h2C01;
        slot("add", 16'h0C01, 0, 1'b1, 1'b1);
        tick();
        op_valid = 1'b0;
        slot("mov", 16'h2C01, 0, 1'b1, 1'b1);
        tick();
        #1;
        check("idle.valid", 32'(dec_valid), 32'd0);

        // RCALL: three slots, NOP waiting behind it
        op_valid = 1'b1;
        op_data  = 16'hD005;
        tick();
        op_data = 16'h0000;
        slot("rcall0", 16'hD005, 0, 1'b0, 1'b0);
        tick();
        slot("rcall1", 16'hD005, 1, 1'b0, 1'b0);
        tick();
        slot("rcall2", 16'hD005, 2, 1'b1, 1'b1);
        tick();
        op_valid = 1'b0;
        slot("nop", 16'h0000, 0, 1'b1, 1'b1);
        tick();

        // CALL 0x1234: EXT cycle then four slots
        op_valid = 1'b1;
        op_data  = 16'h940E;
        tick();
        op_data = 16'h1234;
        #1;
        check("ext.valid", 32'(dec_valid), 32'd0);
        check("ext.ready", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        slot("call0", 16'h940E, 0, 1'b0, 1'b0);
        check("call.two", 32'(dec_two_word), 32'd1);
        check("call.ext", 32'(dec_ext), 32'h1234);
        tick();
        slot("call1", 16'h940E, 1, 1'b0, 1'b0);
        tick();
        slot("call2", 16'h940E, 2, 1'b0, 1'b0);
        tick();
        slot("call3", 16'h940E, 3, 1'b1, 1'b1);
        tick();
        #1;
        check("call.done", 32'(dec_valid), 32'd0);

        // CPSE retires with skip_req; LDS (two words) is swallowed
        op_valid = 1'b1;
        op_data  = 16'h1001;
        tick();
        skip_req = 1'b1;
        op_data  = 16'h9000;
        slot("cpse", 16'h1001, 0, 1'b1, 1'b1);
        tick();
        skip_req = 1'b0;
        op_data  = 16'h0100;
        #1;
        check("skipx.valid", 32'(dec_valid), 32'd0);
        check("skipx.ready", 32'(op_ready), 32'd1);
        tick();
        op_data = 16'h0C01;
        #1;
        check("skip.done.valid", 32'(dec_valid), 32'd0);
        tick();
        op_valid = 1'b0;
        slot("afterskip", 16'h0C01, 0, 1'b1, 1'b1);
        check("afterskip.two", 32'(dec_two_word), 32'd0);
        tick();

        // RET stalled at cycle 1; skip_req during the stall is not a retire
        op_valid = 1'b1;
        op_data  = 16'h9508;
        tick();
        op_valid = 1'b0;
        slot("ret0", 16'h9508, 0, 1'b0, 1'b0);
        tick();
        exec_ready = 1'b0;
        skip_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slot("retstall", 16'h9508, 1, 1'b0, 1'b0);
            tick();
        end
        exec_ready = 1'b1;
        skip_req   = 1'b0;
        slot("ret1", 16'h9508, 1, 1'b0, 1'b0);
        tick();
        slot("ret2", 16'h9508, 2, 1'b0, 1'b0);
        tick();
        op_valid = 1'b1;
        op_data  = 16'h2C01;
        slot("ret3", 16'h9508, 3, 1'b1, 1'b1);
        tick();
        op_valid = 1'b0;
        slot("afterret", 16'h2C01, 0, 1'b1, 1'b1);
        tick();

        // Flush during LPM cycle 1
        op_valid = 1'b1;
        op_data  = 16'h95C8;
        tick();
        op_data = 16'h0C01;
        slot("lpm0", 16'h95C8, 0, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        #1;
        check("lpmflush.ready", 32'(op_ready), 32'd0);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        check("lpmflush.valid", 32'(dec_valid), 32'd0);
        check("lpmflush.ready1", 32'(op_ready), 32'd1);

        // Flush while in EXT of a JMP: no stale ext word
        op_valid = 1'b1;
        op_data  = 16'h940C;
        tick();
        flush   = 1'b1;
        op_data = 16'h5555;
        #1;
        check("extflush.ready", 32'(op_ready), 32'd0);
        tick();
        flush   = 1'b0;
        op_data = 16'h0C01;
        #1;
        check("extflush.valid", 32'(dec_valid), 32'd0);
        check("extflush.ext", 32'(dec_ext), 32'd0);
        check("extflush.ready1", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        slot("afterflush", 16'h0C01, 0, 1'b1, 1'b1);
        check("afterflush.ext", 32'(dec_ext), 32'd0);
        check("afterflush.two", 32'(dec_two_word), 32'd0);
        tick();

        // Asynchronous reset mid-RCALL
        op_valid = 1'b1;
        op_data  = 16'hD005;
        tick();
        op_valid = 1'b0;
        tick();
        slot("rcallpre", 16'hD005, 1, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.valid", 32'(dec_valid), 32'd0);
        check("arst.opcode", 32'(dec_opcode), 32'd0);
        check("arst.cycle", 32'(dec_cycle), 32'd0);
        check("arst.ready", 32'(op_ready), 32'd0);
        check("arst.last", 32'(dec_last), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
